// File: rtl/alu_muldiv_seq_if.sv
// rtl/alu_muldiv_seq_if.sv - request/result and shared-ALU signal bundle for alu_muldiv_seq
interface alu_muldiv_seq_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_result;
  logic             alu_cout;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             div_by_zero;

  // slave is the sequencer; master is the CPU side, which also owns the shared ALU
  modport slave (
    input  start, op, operand_a, operand_b, alu_result, alu_cout,
    output alu_a, alu_b, alu_ctrl, busy, done, result_lo, result_hi, div_by_zero
  );

  modport master (
    output start, op, operand_a, operand_b, alu_result, alu_cout,
    input  alu_a, alu_b, alu_ctrl, busy, done, result_lo, result_hi, div_by_zero
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - shift-add multiply / restoring divide sequencer over a shared external ALU
module alu_muldiv_seq #(
  parameter int         WIDTH   = 64,
  parameter logic [2:0] ALU_ADD = 3'b010,
  parameter logic [2:0] ALU_SUB = 3'b011
) (
  input  logic            clk,
  input  logic            reset,
  alu_muldiv_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  // shared working registers: acc/rem, mcand/quo, mplier/dvs
  logic [WIDTH-1:0] acc_rem;
  logic [WIDTH-1:0] mcand_quo;
  logic [WIDTH-1:0] mplier_dvs;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] res_hi;
  logic             dbz;

  logic [WIDTH-1:0] acc_rem_n;
  logic [WIDTH-1:0] mcand_quo_n;
  logic [WIDTH-1:0] mplier_dvs_n;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_ctrl;
  logic             ge;
  logic             last;
  logic             accept;

  assign shifted = {acc_rem[WIDTH-2:0], mcand_quo[WIDTH-1]};
  // rem MSB set means the 65-bit shifted value already exceeds any divisor
  assign ge      = acc_rem[WIDTH-1] | bus.alu_cout;
  assign last    = (cnt == CW'(WIDTH - 1));
  assign accept  = bus.start & ((state == S_IDLE) | (state == S_DONE));

  always_comb begin
    alu_a        = '0;
    alu_b        = '0;
    alu_ctrl     = ALU_ADD;
    acc_rem_n    = acc_rem;
    mcand_quo_n  = mcand_quo;
    mplier_dvs_n = mplier_dvs;
    case (state)
      S_MUL: begin
        alu_a        = acc_rem;
        alu_b        = mcand_quo;
        alu_ctrl     = ALU_ADD;
        if (mplier_dvs[0]) acc_rem_n = bus.alu_result;
        mcand_quo_n  = mcand_quo << 1;
        mplier_dvs_n = mplier_dvs >> 1;
      end
      S_DIV: begin
        alu_a       = shifted;
        alu_b       = mplier_dvs;
        alu_ctrl    = ALU_SUB;
        acc_rem_n   = ge ? bus.alu_result : shifted;
        mcand_quo_n = {mcand_quo[WIDTH-2:0], ge};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      acc_rem    <= '0;
      mcand_quo  <= '0;
      mplier_dvs <= '0;
      res_lo     <= '0;
      res_hi     <= '0;
      dbz        <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (accept) begin
            cnt     <= '0;
            dbz     <= 1'b0;
            acc_rem <= '0;
            if (!bus.op) begin
              mcand_quo  <= bus.operand_a;
              mplier_dvs <= bus.operand_b;
              state      <= S_MUL;
            end else if (bus.operand_b != '0) begin
              mcand_quo  <= bus.operand_a;
              mplier_dvs <= bus.operand_b;
              state      <= S_DIV;
            end else begin
              res_lo <= '1;
              res_hi <= bus.operand_a;
              dbz    <= 1'b1;
              state  <= S_DONE;
            end
          end
        end
        S_MUL, S_DIV: begin
          acc_rem    <= acc_rem_n;
          mcand_quo  <= mcand_quo_n;
          mplier_dvs <= mplier_dvs_n;
          cnt        <= cnt + CW'(1);
          if (last) begin
            cnt    <= '0;
            state  <= S_DONE;
            res_lo <= (state == S_MUL) ? acc_rem_n : mcand_quo_n;
            res_hi <= (state == S_MUL) ? '0 : acc_rem_n;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.alu_a       = alu_a;
  assign bus.alu_b       = alu_b;
  assign bus.alu_ctrl    = alu_ctrl;
  assign bus.busy        = (state == S_MUL) | (state == S_DIV);
  assign bus.done        = (state == S_DONE);
  assign bus.result_lo   = res_lo;
  assign bus.result_hi   = res_hi;
  assign bus.div_by_zero = dbz;
endmodule
